// File: rtl/oflow_fe_scheduler.sv
// rtl/oflow_fe_scheduler.sv - frame sequencer dispatching bboxes round-robin to NUM_PE feature-extraction units
// Accepts one frame of bboxes, starts free units, collects their results and pulses frame_done.
module oflow_fe_scheduler #(
  parameter int NUM_PE = 4,
  parameter int BBOX_W = 128,
  parameter int CNT_W  = 8,
  localparam int ID_W  = (NUM_PE > 1) ? $clog2(NUM_PE) : 1
) (
  input  logic              clk,
  input  logic              reset_N,
  input  logic              start_frame,
  input  logic [CNT_W-1:0]  num_bbox,
  input  logic [BBOX_W-1:0] bbox_in,
  input  logic              bbox_valid,
  output logic              bbox_ready,
  output logic [BBOX_W-1:0] pe_bbox,
  output logic [NUM_PE-1:0] pe_start_fe,
  input  logic [NUM_PE-1:0] pe_done_fe,
  output logic              res_valid,
  output logic [ID_W-1:0]   res_pe_id,
  input  logic              res_ready,
  output logic              frame_done
);

  typedef enum logic [1:0] {S_IDLE, S_DISPATCH, S_DRAIN, S_DONE} state_e;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  num_q, num_d;
  logic [CNT_W-1:0]  issued_q, issued_d;
  logic [CNT_W-1:0]  done_q, done_d;
  logic [NUM_PE-1:0] busy_q, busy_d;
  logic [NUM_PE-1:0] start_q, start_d;
  logic [1:0]        holdoff_q [NUM_PE];
  logic [1:0]        holdoff_d [NUM_PE];
  logic [ID_W-1:0]   rr_q, rr_d;
  logic [BBOX_W-1:0] bbox_q, bbox_d;
  logic              frame_done_q, frame_done_d;

  logic [NUM_PE-1:0] pend;
  logic [ID_W-1:0]   res_id, sel, cand;
  logic              sel_found, ready_c, res_valid_c, dispatch, collect, collect_ok;

  // Free units come from registered busy, so a unit collected this cycle is not selectable yet.
  always_comb begin
    collect_ok = (state_q == S_DISPATCH) || (state_q == S_DRAIN);
    pend = '0;
    for (int i = 0; i < NUM_PE; i++) begin
      pend[i] = collect_ok && busy_q[i] && (holdoff_q[i] == 2'd0) && pe_done_fe[i];
    end
    res_id = '0;
    for (int i = NUM_PE - 1; i >= 0; i--) begin
      if (pend[i]) res_id = ID_W'(i);
    end
    res_valid_c = |pend;
    ready_c     = (state_q == S_DISPATCH) && !(&busy_q) && (issued_q < num_q);
    sel         = '0;
    cand        = '0;
    sel_found   = 1'b0;
    for (int k = 0; k < NUM_PE; k++) begin
      cand = ID_W'((int'(rr_q) + k) % NUM_PE);
      if (!sel_found && !busy_q[cand]) begin
        sel       = cand;
        sel_found = 1'b1;
      end
    end
    dispatch = bbox_valid && ready_c;
    collect  = res_valid_c && res_ready;
  end

  always_comb begin
    state_d      = state_q;
    num_d        = num_q;
    issued_d     = issued_q;
    done_d       = done_q;
    busy_d       = busy_q;
    rr_d         = rr_q;
    bbox_d       = bbox_q;
    start_d      = '0;
    frame_done_d = (state_q == S_DONE);
    // holdoff masks the done level still high from the unit's previous job
    for (int i = 0; i < NUM_PE; i++) begin
      holdoff_d[i] = (holdoff_q[i] != 2'd0) ? holdoff_q[i] - 2'd1 : 2'd0;
    end
    if (collect) begin
      busy_d[res_id] = 1'b0;
      done_d         = done_q + CNT_W'(1);
    end
    if (dispatch) begin
      busy_d[sel]    = 1'b1;
      holdoff_d[sel] = 2'd2;
      start_d[sel]   = 1'b1;
      bbox_d         = bbox_in;
      rr_d           = (sel == ID_W'(NUM_PE - 1)) ? '0 : sel + ID_W'(1);
      issued_d       = issued_q + CNT_W'(1);
    end
    unique case (state_q)
      S_IDLE: begin
        if (start_frame) begin
          num_d    = num_bbox;
          issued_d = '0;
          done_d   = '0;
          state_d  = (num_bbox == '0) ? S_DONE : S_DISPATCH;
        end
      end
      S_DISPATCH: if (issued_d == num_q) state_d = S_DRAIN;
      S_DRAIN:    if (done_q == num_q) state_d = S_DONE;
      S_DONE:     state_d = S_IDLE;
      default:    state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q      <= S_IDLE;
      num_q        <= '0;
      issued_q     <= '0;
      done_q       <= '0;
      busy_q       <= '0;
      start_q      <= '0;
      rr_q         <= '0;
      bbox_q       <= '0;
      frame_done_q <= 1'b0;
      for (int i = 0; i < NUM_PE; i++) holdoff_q[i] <= 2'd0;
    end else begin
      state_q      <= state_d;
      num_q        <= num_d;
      issued_q     <= issued_d;
      done_q       <= done_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
      rr_q         <= rr_d;
      bbox_q       <= bbox_d;
      frame_done_q <= frame_done_d;
      for (int i = 0; i < NUM_PE; i++) holdoff_q[i] <= holdoff_d[i];
    end
  end

  assign bbox_ready  = ready_c;
  assign pe_bbox     = bbox_q;
  assign pe_start_fe = start_q;
  assign res_valid   = res_valid_c;
  assign res_pe_id   = res_id;
  assign frame_done  = frame_done_q;

endmodule

// File: tb/tb_oflow_fe_scheduler.sv
// tb/tb_oflow_fe_scheduler.sv - scoreboard bench for oflow_fe_scheduler
// Unit models answer LAT cycles after their start pulse unless stalled; expected dispatches are queued.
module tb_oflow_fe_scheduler;
  localparam int NUM_PE = 4;
  localparam int BBOX_W = 128;
  localparam int CNT_W  = 8;
  localparam int ID_W   = 2;
  localparam int LAT    = 3;

  logic              clk = 1'b0;
  logic              reset_N = 1'b0;
  logic              start_frame = 1'b0;
  logic [CNT_W-1:0]  num_bbox = '0;
  logic [BBOX_W-1:0] bbox_in = '0;
  logic              bbox_valid = 1'b0;
  logic              bbox_ready;
  logic [BBOX_W-1:0] pe_bbox;
  logic [NUM_PE-1:0] pe_start_fe;
  logic [NUM_PE-1:0] pe_done_fe;
  logic              res_valid;
  logic [ID_W-1:0]   res_pe_id;
  logic              res_ready = 1'b0;
  logic              frame_done;

  logic [NUM_PE-1:0] mdl_done;
  logic [NUM_PE-1:0] stall = '0;
  logic [NUM_PE-1:0] done_force = '0;
  int                rem [NUM_PE];

  typedef struct {
    int                unit;
    logic [BBOX_W-1:0] data;
  } disp_t;

  disp_t exp_q[$];
  time   start_t[$];
  int    n_checks = 0;
  int    n_pass = 0;
  int    fd_cnt = 0;
  int    res_cnt = 0;

  oflow_fe_scheduler #(.NUM_PE(NUM_PE), .BBOX_W(BBOX_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset_N(reset_N), .start_frame(start_frame), .num_bbox(num_bbox),
    .bbox_in(bbox_in), .bbox_valid(bbox_valid), .bbox_ready(bbox_ready),
    .pe_bbox(pe_bbox), .pe_start_fe(pe_start_fe), .pe_done_fe(pe_done_fe),
    .res_valid(res_valid), .res_pe_id(res_pe_id), .res_ready(res_ready),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;
  assign pe_done_fe = mdl_done | done_force;

  always @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      mdl_done <= '0;
      for (int i = 0; i < NUM_PE; i++) rem[i] <= 0;
    end else begin
      for (int i = 0; i < NUM_PE; i++) begin
        if (pe_start_fe[i]) begin
          rem[i] <= LAT;
          mdl_done[i] <= 1'b0;
        end else if (rem[i] > 1) begin
          rem[i] <= rem[i] - 1;
        end else if (rem[i] == 1 && !stall[i]) begin
          rem[i] <= 0;
          mdl_done[i] <= 1'b1;
        end
      end
    end
  end

  disp_t mon_e;
  logic [NUM_PE-1:0] mon_oh;
  always @(negedge clk) begin
    if (frame_done) fd_cnt++;
    if (res_valid && res_ready) res_cnt++;
    if (pe_start_fe != '0) begin
      start_t.push_back($time);
      n_checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL unexpected_start: got pe_start_fe=%b, expected no start", pe_start_fe);
      end else begin
        mon_e = exp_q.pop_front();
        mon_oh = '0;
        mon_oh[mon_e.unit] = 1'b1;
        if (pe_start_fe !== mon_oh || pe_bbox !== mon_e.data)
          $display("FAIL dispatch: got start=%b bbox=%h, expected start=%b bbox=%h",
                   pe_start_fe, pe_bbox, mon_oh, mon_e.data);
        else n_pass++;
      end
    end
  end

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic begin_frame(input int n);
    start_frame = 1'b1;
    num_bbox = CNT_W'(n);
    tick();
    start_frame = 1'b0;
    num_bbox = '0;
  endtask

  task automatic send_bbox(input int unit);
    logic [BBOX_W-1:0] d;
    bit got = 0;
    d = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back('{unit: unit, data: d});
    bbox_in = d;
    bbox_valid = 1'b1;
    for (int n = 0; n < 64 && !got; n++) begin
      #1;
      got = bbox_ready;
      tick();
    end
    bbox_valid = 1'b0;
    n_checks++;
    if (!got) begin
      $display("FAIL send_timeout: got no bbox_ready, expected handshake for unit %0d", unit);
      void'(exp_q.pop_back());
    end else n_pass++;
  endtask

  task automatic wait_frame_done(input string name);
    bit got = 0;
    for (int n = 0; n < 64 && !got; n++) begin
      if (frame_done) got = 1;
      else tick();
    end
    n_checks++;
    if (!got) $display("FAIL %s_frame_done: got no pulse in 64 cycles, expected one", name);
    else n_pass++;
    tick();
  endtask

  task automatic test_reset();
    tick();
    n_checks++;
    if ({bbox_ready, pe_start_fe, res_valid, res_pe_id, frame_done} !== '0 || pe_bbox !== '0)
      $display("FAIL reset_outputs: got ready=%b start=%b bbox=%h rv=%b id=%0d fd=%b, expected all 0",
               bbox_ready, pe_start_fe, pe_bbox, res_valid, res_pe_id, frame_done);
    else n_pass++;
    reset_N = 1'b1;
    tick();
    bbox_valid = 1'b1;
    #1;
    n_checks++;
    if (bbox_ready !== 1'b0) $display("FAIL idle_ready: got %b, expected 0", bbox_ready);
    else n_pass++;
    bbox_valid = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    int fd0 = fd_cnt, r0 = res_cnt, span;
    stall = '0; res_ready = 1'b1;
    start_t.delete();
    begin_frame(3);
    send_bbox(0); send_bbox(1); send_bbox(2);
    wait_frame_done("t1");
    tick(); tick();
    span = (start_t.size() == 3) ? int'(start_t[2] - start_t[0]) : -1;
    n_checks++;
    if (span !== 20) $display("FAIL t1_consecutive: got span %0d, expected 20", span);
    else n_pass++;
    n_checks++;
    if (res_cnt - r0 !== 3) $display("FAIL t1_results: got %0d, expected 3", res_cnt - r0);
    else n_pass++;
    n_checks++;
    if (fd_cnt - fd0 !== 1) $display("FAIL t1_frame_done_count: got %0d, expected 1", fd_cnt - fd0);
    else n_pass++;
  endtask

  task automatic test_stall_full();
    int fd0 = fd_cnt, r0 = res_cnt;
    bit got = 0;
    logic [BBOX_W-1:0] d;
    stall = '1; res_ready = 1'b1;
    begin_frame(6);
    send_bbox(3); send_bbox(0); send_bbox(1); send_bbox(2);
    d = {$urandom, $urandom, $urandom, $urandom};
    exp_q.push_back('{unit: 2, data: d});
    bbox_in = d;
    bbox_valid = 1'b1;
    for (int n = 0; n < 3; n++) begin
      #1;
      n_checks++;
      if (bbox_ready !== 1'b0) $display("FAIL t2_full_ready: got %b, expected 0", bbox_ready);
      else n_pass++;
      tick();
    end
    stall[2] = 1'b0;
    for (int n = 0; n < 10 && !got; n++) begin
      #1;
      if (res_valid) got = 1;
      else tick();
    end
    n_checks++;
    if (!got || res_pe_id !== 2'd2 || bbox_ready !== 1'b0)
      $display("FAIL t2_collect: got valid=%b id=%0d ready=%b, expected 1 2 0", got, res_pe_id, bbox_ready);
    else n_pass++;
    tick();
    #1;
    n_checks++;
    if (bbox_ready !== 1'b1) $display("FAIL t2_ready_after_free: got %b, expected 1", bbox_ready);
    else n_pass++;
    tick();
    n_checks++;
    if (pe_start_fe !== 4'b0100) $display("FAIL t2_restart_unit2: got %b, expected 0100", pe_start_fe);
    else n_pass++;
    bbox_valid = 1'b0;
    stall = '0;
    repeat (12) tick();
    send_bbox(3);
    wait_frame_done("t2");
    tick();
    n_checks++;
    if (res_cnt - r0 !== 6 || fd_cnt - fd0 !== 1)
      $display("FAIL t2_totals: got res=%0d fd=%0d, expected 6 1", res_cnt - r0, fd_cnt - fd0);
    else n_pass++;
  endtask

  task automatic test_stale_mask();
    stall = '1; res_ready = 1'b0; done_force[0] = 1'b1;
    begin_frame(1);
    send_bbox(0);
    #1;
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL t3_mask_c0: got %b, expected 0", res_valid);
    else n_pass++;
    tick();
    n_checks++;
    if (res_valid !== 1'b0) $display("FAIL t3_mask_c1: got %b, expected 0", res_valid);
    else n_pass++;
    @(posedge clk);
    done_force = '0;
    tick();
    for (int n = 0; n < 2; n++) begin
      n_checks++;
      if (res_valid !== 1'b0) $display("FAIL t3_no_done: got %b, expected 0", res_valid);
      else n_pass++;
      tick();
    end
    stall[0] = 1'b0;
    tick();
    for (int n = 0; n < 2; n++) begin
      n_checks++;
      if (res_valid !== 1'b1 || res_pe_id !== 2'd0)
        $display("FAIL t3_result_held: got valid=%b id=%0d, expected 1 0", res_valid, res_pe_id);
      else n_pass++;
      tick();
    end
    res_ready = 1'b1;
    wait_frame_done("t3");
  endtask

  task automatic test_simul_pending();
    int r0;
    stall = '1; res_ready = 1'b0;
    begin_frame(4);
    send_bbox(1); send_bbox(2); send_bbox(3); send_bbox(0);
    repeat (4) tick();
    res_ready = 1'b1;
    stall = 4'b0101;
    r0 = res_cnt;
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || res_pe_id !== 2'd1)
      $display("FAIL t4_first: got valid=%b id=%0d, expected 1 1", res_valid, res_pe_id);
    else n_pass++;
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || res_pe_id !== 2'd3)
      $display("FAIL t4_second: got valid=%b id=%0d, expected 1 3", res_valid, res_pe_id);
    else n_pass++;
    tick();
    n_checks++;
    if (res_valid !== 1'b0 || res_cnt - r0 !== 2)
      $display("FAIL t4_after: got valid=%b collected=%0d, expected 0 2", res_valid, res_cnt - r0);
    else n_pass++;
    stall = '0;
    wait_frame_done("t4");
  endtask

  task automatic test_empty_and_ignore();
    int fd0 = fd_cnt, r0 = res_cnt;
    logic [2:0] seen;
    res_ready = 1'b1; stall = '0;
    start_t.delete();
    start_frame = 1'b1; num_bbox = '0;
    tick();
    start_frame = 1'b0;
    seen[0] = frame_done; tick();
    seen[1] = frame_done; tick();
    seen[2] = frame_done; tick();
    n_checks++;
    if (seen !== 3'b010 || start_t.size() != 0)
      $display("FAIL t5_empty: got seq=%b starts=%0d, expected 010 0", seen, start_t.size());
    else n_pass++;
    stall = '1;
    begin_frame(2);
    send_bbox(1);
    start_frame = 1'b1; num_bbox = 8'd5;
    tick();
    start_frame = 1'b0; num_bbox = '0;
    send_bbox(2);
    bbox_valid = 1'b1;
    #1;
    n_checks++;
    if (bbox_ready !== 1'b0) $display("FAIL t5_ignore_ready: got %b, expected 0", bbox_ready);
    else n_pass++;
    bbox_valid = 1'b0;
    stall = '0;
    wait_frame_done("t5");
    tick();
    n_checks++;
    if (fd_cnt - fd0 !== 2 || res_cnt - r0 !== 2)
      $display("FAIL t5_totals: got fd=%0d res=%0d, expected 2 2", fd_cnt - fd0, res_cnt - r0);
    else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int fd0, r0;
    stall = '1; res_ready = 1'b0;
    begin_frame(2);
    send_bbox(3); send_bbox(0);
    repeat (4) tick();
    stall[3] = 1'b0;
    tick();
    n_checks++;
    if (res_valid !== 1'b1 || res_pe_id !== 2'd3)
      $display("FAIL t6_pre: got valid=%b id=%0d, expected 1 3", res_valid, res_pe_id);
    else n_pass++;
    reset_N = 1'b0;
    #1;
    n_checks++;
    if ({bbox_ready, pe_start_fe, res_valid, res_pe_id, frame_done} !== '0 || pe_bbox !== '0)
      $display("FAIL t6_reset_outputs: got ready=%b start=%b bbox=%h rv=%b id=%0d fd=%b, expected all 0",
               bbox_ready, pe_start_fe, pe_bbox, res_valid, res_pe_id, frame_done);
    else n_pass++;
    tick(); tick();
    reset_N = 1'b1; stall = '0; res_ready = 1'b1;
    fd0 = fd_cnt;
    repeat (5) tick();
    n_checks++;
    if (fd_cnt - fd0 !== 0 || res_valid !== 1'b0)
      $display("FAIL t6_aborted: got fd=%0d rv=%b, expected 0 0", fd_cnt - fd0, res_valid);
    else n_pass++;
    r0 = res_cnt;
    begin_frame(2);
    send_bbox(0); send_bbox(1);
    wait_frame_done("t6");
    tick();
    n_checks++;
    if (fd_cnt - fd0 !== 1 || res_cnt - r0 !== 2 || exp_q.size() != 0)
      $display("FAIL t6_next_frame: got fd=%0d res=%0d pending=%0d, expected 1 2 0",
               fd_cnt - fd0, res_cnt - r0, exp_q.size());
    else n_pass++;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_stall_full();
    test_stale_mask();
    test_simul_pending();
    test_empty_and_ignore();
    test_reset_midframe();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
